// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access.
// Data wins by default; fetch is forced after MAX_IF_WAIT consecutive data grants.
//
// state    | meaning
// IDLE     | grant decision made from live requests
// SERVE_IF | fetch access in flight, waiting for mem_ack
// SERVE_DM | data access in flight, waiting for mem_ack
// DONE_IF  | if_done pulse, requests not sampled
// DONE_DM  | dm_done pulse, requests not sampled
module mem_port_arbiter #(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int MAX_IF_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_done,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    localparam int CNT_W = (MAX_IF_WAIT < 1) ? 1 : $clog2(MAX_IF_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IF_WAIT);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE_IF = 3'd1,
        SERVE_DM = 3'd2,
        DONE_IF  = 3'd3,
        DONE_DM  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             latched_we;
    logic             grant_dm;
    logic             grant_if;

    // Data loses only when a pending fetch has already waited the full budget.
    assign grant_dm = dm_req && !(if_req && (cnt == CNT_MAX));
    assign grant_if = !grant_dm && if_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_dm) begin
                    state_nxt = SERVE_DM;
                end else if (grant_if) begin
                    state_nxt = SERVE_IF;
                end
            end
            SERVE_IF: if (mem_ack) state_nxt = DONE_IF;
            SERVE_DM: if (mem_ack) state_nxt = DONE_DM;
            DONE_IF:  state_nxt = IDLE;
            DONE_DM:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req   = (state == SERVE_IF) || (state == SERVE_DM);
        mem_we    = (state == SERVE_DM) && latched_we;
        if_done   = (state == DONE_IF);
        dm_done   = (state == DONE_DM);
        stall_if  = if_req && !if_done;
        stall_mem = dm_req && !dm_done;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            latched_we <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        mem_addr   <= dm_addr;
                        mem_wdata  <= dm_wdata;
                        latched_we <= dm_we;
                        if (!if_req) begin
                            cnt <= '0;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 1'b1;
                        end
                    end else if (grant_if) begin
                        mem_addr   <= if_addr;
                        latched_we <= 1'b0;
                        cnt        <= '0;
                    end
                end
                SERVE_IF: if (mem_ack) if_rdata <= mem_rdata;
                // Stores complete without touching the load-data register.
                SERVE_DM: if (mem_ack && !latched_we) dm_rdata <= mem_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed-vector bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_done;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              stall_if;
    logic              stall_mem;

    int vec_cnt = 0;
    int err_cnt = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_IF_WAIT(3)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_done   (dm_done),
        .dm_rdata  (dm_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1ns after the rising edge; inputs set here apply to the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".mem_req"},   32'(mem_req),   32'h0);
        check({tag, ".mem_we"},    32'(mem_we),    32'h0);
        check({tag, ".mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, ".mem_wdata"}, mem_wdata,      32'h0);
        check({tag, ".if_done"},   32'(if_done),   32'h0);
        check({tag, ".dm_done"},   32'(dm_done),   32'h0);
        check({tag, ".if_rdata"},  if_rdata,       32'h0);
        check({tag, ".dm_rdata"},  dm_rdata,       32'h0);
        check({tag, ".stall_if"},  32'(stall_if),  32'h0);
        check({tag, ".stall_mem"}, 32'(stall_mem), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] exp_order [8];
        logic [ADDR_W-1:0] f_addr [3];
        logic [DATA_W-1:0] f_data [3];
        int grants;
        int k;
        int last_done;

        reset = 1'b1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0; mem_ack = 0; mem_rdata = '0;
        tick(); tick();
        reset = 1'b0;
        check_all_zero("reset");

        // Single fetch
        if_req = 1; if_addr = 9'h010;
        #1 check("t1.stall_if_idle", 32'(stall_if), 32'h1);
        tick();
        check("t1.mem_req", 32'(mem_req), 32'h1);
        check("t1.mem_addr", 32'(mem_addr), 32'h010);
        check("t1.mem_we", 32'(mem_we), 32'h0);
        check("t1.stall_if_serve", 32'(stall_if), 32'h1);
        mem_ack = 1; mem_rdata = 32'h00500093;
        tick();
        check("t1.mem_req_done", 32'(mem_req), 32'h0);
        check("t1.if_done", 32'(if_done), 32'h1);
        check("t1.if_rdata", if_rdata, 32'h00500093);
        check("t1.stall_if_done", 32'(stall_if), 32'h0);
        if_req = 0; mem_ack = 0;
        tick();
        check("t1.if_done_gone", 32'(if_done), 32'h0);
        check("t1.mem_req_idle", 32'(mem_req), 32'h0);

        // Contention: data first, fetch right after
        if_req = 1; if_addr = 9'h100; dm_req = 1; dm_we = 0; dm_addr = 9'h040;
        tick();
        check("t2.dm_mem_req", 32'(mem_req), 32'h1);
        check("t2.dm_mem_addr", 32'(mem_addr), 32'h040);
        mem_ack = 1; mem_rdata = 32'h12345678;
        tick();
        check("t2.dm_done", 32'(dm_done), 32'h1);
        check("t2.dm_rdata", dm_rdata, 32'h12345678);
        check("t2.if_rdata_held", if_rdata, 32'h00500093);
        check("t2.stall_if", 32'(stall_if), 32'h1);
        check("t2.stall_mem", 32'(stall_mem), 32'h0);
        dm_req = 0; mem_ack = 0;
        tick();
        check("t2.idle_mem_req", 32'(mem_req), 32'h0);
        tick();
        check("t2.if_mem_req", 32'(mem_req), 32'h1);
        check("t2.if_mem_addr", 32'(mem_addr), 32'h100);
        mem_ack = 1; mem_rdata = 32'h00000013;
        tick();
        check("t2.if_done", 32'(if_done), 32'h1);
        check("t2.if_rdata", if_rdata, 32'h00000013);
        if_req = 0; mem_ack = 0;
        tick();

        // Starvation bound: DM DM DM IF DM DM DM IF
        exp_order = '{9'h080, 9'h080, 9'h080, 9'h004, 9'h080, 9'h080, 9'h080, 9'h004};
        if_req = 1; if_addr = 9'h004; dm_req = 1; dm_we = 0; dm_addr = 9'h080;
        mem_ack = 1; mem_rdata = 32'hCAFE0001;
        grants = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (mem_req) begin
                if (grants < 8) check($sformatf("t3.grant%0d", grants), 32'(mem_addr), 32'(exp_order[grants]));
                grants++;
            end
        end
        check("t3.grant_count", 32'(grants), 32'd8);
        if_req = 0; dm_req = 0; mem_ack = 0;
        tick();
        check("t3.idle_after", 32'(mem_req), 32'h0);

        // Store with delayed ack and toggling requester inputs
        dm_req = 1; dm_we = 1; dm_addr = 9'h020; dm_wdata = 32'hDEADBEEF;
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4.mem_req%0d", i), 32'(mem_req), 32'h1);
            check($sformatf("t4.mem_we%0d", i), 32'(mem_we), 32'h1);
            check($sformatf("t4.mem_addr%0d", i), 32'(mem_addr), 32'h020);
            check($sformatf("t4.mem_wdata%0d", i), mem_wdata, 32'hDEADBEEF);
            check($sformatf("t4.dm_done%0d", i), 32'(dm_done), 32'h0);
            mem_ack = (i == 4);
            mem_rdata = 32'h55555555;
            dm_we = i[0]; dm_addr = 9'h1FF ^ 9'(i); dm_wdata = 32'(i);
            if_req = (i < 4) ? i[0] : 1'b0;
            tick();
        end
        check("t4.dm_done", 32'(dm_done), 32'h1);
        check("t4.mem_req_done", 32'(mem_req), 32'h0);
        check("t4.mem_we_done", 32'(mem_we), 32'h0);
        check("t4.dm_rdata_kept", dm_rdata, 32'hCAFE0001);
        dm_req = 0; if_req = 0; mem_ack = 0;
        tick();
        check("t4.dm_done_single", 32'(dm_done), 32'h0);

        // Reset during SERVE_IF, late ack afterwards
        if_req = 1; if_addr = 9'h0A0; dm_we = 0;
        tick();
        check("t5.serve", 32'(mem_req), 32'h1);
        reset = 1; if_req = 0;
        tick();
        check_all_zero("t5.post_reset");
        reset = 0; mem_ack = 1; mem_rdata = 32'h77777777;
        tick();
        check("t5.late_ack_done", 32'(if_done), 32'h0);
        check("t5.late_ack_rdata", if_rdata, 32'h0);
        check("t5.late_ack_req", 32'(mem_req), 32'h0);
        mem_ack = 0;
        tick();
        check("t5.still_no_done", 32'(if_done), 32'h0);

        // Back-to-back fetches
        f_addr = '{9'h000, 9'h004, 9'h008};
        f_data = '{32'h00000013, 32'h00100093, 32'h00200113};
        k = 0; last_done = 0;
        if_req = 1; if_addr = f_addr[0]; mem_ack = 1; mem_rdata = f_data[0];
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (mem_req && k < 3) check($sformatf("t6.addr%0d", k), 32'(mem_addr), 32'(f_addr[k]));
            if (if_done) begin
                if (k < 3) check($sformatf("t6.data%0d", k), if_rdata, f_data[k]);
                if (k > 0) check($sformatf("t6.gap%0d", k), 32'(c - last_done), 32'd3);
                last_done = c;
                k++;
                if (k < 3) begin
                    if_addr = f_addr[k];
                    mem_rdata = f_data[k];
                end else begin
                    if_req = 0;
                    mem_ack = 0;
                end
            end
        end
        check("t6.done_count", 32'(k), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester and the data-memory (MEM-stage) requester of the 5-stage pipeline.
- Sequences each access with a req/ack handshake toward memory and a done pulse toward the requester.
- Generates stall signals for both pipeline stages.
- Gives data accesses priority, with a bounded-starvation guarantee for fetch.

Parameters:
ADDR_W, 9, memory byte-address width (matches PC/DM address width)
DATA_W, 32, data word width
MAX_IF_WAIT, 3, maximum consecutive data grants while a fetch is pending before fetch is forced

Ports:
clk  input  1  global clock
reset  input  1  synchronous, active-high reset
if_req  input  1  fetch request; held high until if_done
if_addr  input  ADDR_W  fetch address
if_done  output  1  one-cycle pulse; if_rdata valid
if_rdata  output  DATA_W  fetched instruction word
dm_req  input  1  data request; held high until dm_done
dm_we  input  1  1 = store, 0 = load
dm_addr  input  ADDR_W  data address
dm_wdata  input  DATA_W  store data
dm_done  output  1  one-cycle pulse; access complete
dm_rdata  output  DATA_W  load data
mem_req  output  1  memory access request
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_ack  input  1  memory completes current access this cycle
mem_rdata  input  DATA_W  read data, valid with mem_ack
stall_if  output  1  fetch stage must hold
stall_mem  output  1  MEM stage must hold

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: every output is 0, FSM is IDLE, starvation counter is 0.
- FSM states: IDLE, SERVE_IF, SERVE_DM, DONE_IF, DONE_DM.
- IDLE:
  - If dm_req && !(if_req && cnt==MAX_IF_WAIT), go to SERVE_DM.
  - Else if if_req, go to SERVE_IF.
  - Else stay in IDLE.
  - On entering a SERVE state, latch the winning address, and for data also latch we/wdata, into mem_addr/mem_we/mem_wdata registers.
- SERVE_x:
  - mem_req=1; mem_addr/mem_we/mem_wdata held stable from the latched values.
  - Requester inputs are ignored in this state.
  - On mem_ack: capture mem_rdata (fetch, or data load only) and go to DONE_x. Without ack, stay (unbounded wait).
- DONE_x:
  - mem_req=0; x_done=1 for exactly this cycle; then go to IDLE.
  - Requests are not sampled in DONE. A req still high in the following IDLE cycle is a new request.
- Latency: request seen in IDLE at cycle N; mem_req asserted cycle N+1; with ack at N+1, done at N+2, next grant decision at N+3. Minimum 3 cycles per access.
- mem_we=1 only in SERVE_DM with a latched dm_we=1. Stores never modify dm_rdata.
- if_rdata and dm_rdata hold their last captured values until the next capture.
- Starvation counter cnt, range 0..MAX_IF_WAIT:
  - Increments on each SERVE_DM grant made while if_req=1.
  - Clears on a SERVE_IF grant, or on any grant made while if_req=0.
  - Saturates at MAX_IF_WAIT; no wrap-around.
- stall_if = if_req && !if_done; stall_mem = dm_req && !dm_done (combinational on registered done).
- mem_ack outside SERVE states is ignored: no capture, no done.
- Reset in SERVE_x: next cycle mem_req=0 and state is IDLE. The aborted access produces no done pulse, and a late ack is ignored.
- Simultaneous if_req and dm_req at reset release: data is granted first (cnt=0).

Test Plan:
1. Single fetch: if_req=1, if_addr=0x010, ack in the first SERVE cycle with mem_rdata=0x00500093 -> mem_req=1 with mem_addr=0x010 exactly one cycle; if_done pulse one cycle later with if_rdata=0x00500093; stall_if=1 until then.
2. Contention: if_req and dm_req (load 0x040, mem_rdata=0x12345678) raised in the same cycle -> data served first with dm_rdata=0x12345678; fetch granted in the IDLE cycle immediately after DONE_DM.
3. Starvation, MAX_IF_WAIT=3, both requests held high continuously with instant acks -> grant order DM, DM, DM, IF, DM, DM, DM, IF.
4. Store: dm_we=1, dm_addr=0x020, dm_wdata=0xDEADBEEF, ack delayed 4 cycles, requester inputs toggled during the wait -> mem_we=1 with addr/wdata stable for all 5 SERVE cycles; one dm_done; dm_rdata unchanged.
5. Reset asserted during SERVE_IF with ack pending, ack arriving after reset deasserts -> mem_req=0 the cycle after reset; all outputs 0; no if_done generated.
6. Back-to-back fetches: if_req held high, addresses 0x000/0x004/0x008, instant acks -> three if_done pulses spaced exactly 3 cycles apart with the matching data words.
